// File: rtl/divisor_sequencial_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// default operand width and the divide-by-zero quotient constant.
package divisor_sequencial_pkg;

    localparam int DEFAULT_SIZE = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Quotient reported when the divisor is zero (every bit set).
    localparam logic [DEFAULT_SIZE-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/divisor_sequencial_if.sv
// Request/response bundle between the control unit and the divider.
interface divisor_sequencial_if
    import divisor_sequencial_pkg::*;
#(
    parameter int SIZE = DEFAULT_SIZE
);
    logic            start;
    logic            sinal;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic            busy;
    logic            done;
    logic [SIZE-1:0] quociente;
    logic [SIZE-1:0] resto;
    logic            div_zero;

    modport master (
        output start, sinal, a, b,
        input  busy, done, quociente, resto, div_zero
    );

    modport slave (
        input  start, sinal, a, b,
        output busy, done, quociente, resto, div_zero
    );
endinterface

// File: rtl/somador32bits.sv
// Parameterised ripple adder with carry in/out; the divider uses it as the
// trial subtractor (a + ~b + 1).
module somador32bits #(
    parameter int SIZE = 32
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            cin,
    output logic [SIZE-1:0] s,
    output logic            cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SIZE{1'b0}}, cin};
endmodule

// File: rtl/divisor_sequencial.sv
// Iterative restoring divider for DIV/DIVU: one shift-and-trial-subtract step
// per clock on magnitudes, then a single fix-up cycle applies signs.
module divisor_sequencial
    import divisor_sequencial_pkg::*;
#(
    parameter int SIZE = DEFAULT_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    divisor_sequencial_if.slave  bus
);
    localparam int              CNT_W = $clog2(SIZE);
    localparam logic [SIZE-1:0] ONE   = SIZE'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SIZE:0]    rem_q, rem_d;
    logic [SIZE-1:0]  dvd_q, dvd_d;
    logic [SIZE-1:0]  dvs_q, dvs_d;
    logic [SIZE-1:0]  raw_a_q, raw_a_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             zero_q, zero_d;
    logic [SIZE-1:0]  quo_q, quo_d;
    logic [SIZE-1:0]  res_q, res_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;

    logic [SIZE:0]    shifted;
    logic [SIZE:0]    trial_b;
    logic [SIZE:0]    trial;
    logic             trial_cout;
    logic [SIZE-1:0]  abs_a, abs_b;
    logic             unused_rem_msb;

    // Magnitudes of the incoming operands (negated only for signed negatives).
    assign abs_a = (bus.sinal && bus.a[SIZE-1]) ? (~bus.a + ONE) : bus.a;
    assign abs_b = (bus.sinal && bus.b[SIZE-1]) ? (~bus.b + ONE) : bus.b;

    // The partial remainder never exceeds |b|-1, so its top bit is always 0
    // before the shift and drops out of the next step.
    assign shifted        = {rem_q[SIZE-1:0], dvd_q[SIZE-1]};
    assign trial_b        = ~{1'b0, dvs_q};
    assign unused_rem_msb = rem_q[SIZE];

    // Trial subtraction rem - |b|; carry out set means the result is non-negative.
    somador32bits #(.SIZE(SIZE + 1)) u_trial (
        .a    (shifted),
        .b    (trial_b),
        .cin  (1'b1),
        .s    (trial),
        .cout (trial_cout)
    );

    // Next-state and datapath update for the IDLE/CALC/FIX sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        raw_a_d = raw_a_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        zero_d  = zero_q;
        quo_d   = quo_q;
        res_d   = res_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dvd_d   = abs_a;
                    dvs_d   = abs_b;
                    raw_a_d = bus.a;
                    qneg_d  = bus.sinal & (bus.a[SIZE-1] ^ bus.b[SIZE-1]);
                    rneg_d  = bus.sinal & bus.a[SIZE-1];
                    rem_d   = '0;
                    cnt_d   = '0;
                    zero_d  = (bus.b == '0);
                    state_d = (bus.b == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                rem_d = trial_cout ? trial : shifted;
                dvd_d = {dvd_q[SIZE-2:0], trial_cout};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(SIZE - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (zero_q) begin
                    quo_d = {SIZE{DIV0_QUOTIENT[0]}};
                    res_d = raw_a_q;
                    dz_d  = 1'b1;
                end else begin
                    quo_d = qneg_q ? (~dvd_q + ONE) : dvd_q;
                    res_d = rneg_q ? (~rem_q[SIZE-1:0] + ONE) : rem_q[SIZE-1:0];
                    dz_d  = 1'b0;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything, outputs included.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            raw_a_q <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            zero_q  <= 1'b0;
            quo_q   <= '0;
            res_q   <= '0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            raw_a_q <= raw_a_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            zero_q  <= zero_d;
            quo_q   <= quo_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.quociente = quo_q;
    assign bus.resto     = res_q;
    assign bus.div_zero  = dz_q;
endmodule
